// File: rtl/srio_resp_pkg.sv
// Shared definitions for the SRIO logical-layer response path.
// State encoding, FTYPE codes, TUSER field positions and an index-width helper.
package srio_resp_pkg;

  typedef enum logic {
    IDLE_s = 1'b0,
    PKT_s  = 1'b1
  } arb_state_t;

  localparam logic [3:0] FTYPE_DOORB  = 4'hA;
  localparam logic [3:0] FTYPE_NWRITE = 4'h5;
  localparam logic [3:0] FTYPE_RESP   = 4'hD;
  localparam logic [3:0] FTYPE_MAINT  = 4'h8;

  // tuser = {src_id, des_id}
  localparam int TUSER_SRC_MSB = 31;
  localparam int TUSER_SRC_LSB = 16;
  localparam int TUSER_DES_MSB = 15;
  localparam int TUSER_DES_LSB = 0;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tresp_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request after i_last, wrapping.
// Reusable by any arbiter that keeps its own last-grant pointer.
module rr_pick
  import srio_resp_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_pick_oh,
  output logic [IW-1:0] o_pick_idx,
  output logic          o_pick_vld
);

  // Scan offsets 1..N from the last grant, so the previous winner is considered last.
  always_comb begin
    o_pick_oh  = '0;
    o_pick_idx = '0;
    o_pick_vld = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!o_pick_vld && i_req[i] && (i == ((int'(i_last) + k) % N))) begin
          o_pick_vld    = 1'b1;
          o_pick_oh[i]  = 1'b1;
          o_pick_idx    = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/tresp_arbiter.sv
// Packet-locked round-robin arbiter for the SRIO tresp channel (log_clk domain).
// Optional per-port packet counters are built when RESP_ARB_STATS_EN is defined.
//
// state  | meaning
// IDLE_s | no owner; arbitrate among valid ports, grant lands next cycle
// PKT_s  | granted port passes through until its tlast beat transfers
module tresp_arbiter
  import srio_resp_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int CNT_W     = 16
) (
  input  logic                       log_clk,
  input  logic                       log_rst,
  input  logic [NUM_PORTS-1:0]       src_tvalid_in,
  output logic [NUM_PORTS-1:0]       src_tready_o,
  input  logic [NUM_PORTS-1:0]       src_tlast_in,
  input  logic [NUM_PORTS*64-1:0]    src_tdata_in,
  input  logic [NUM_PORTS*8-1:0]     src_tkeep_in,
  input  logic [NUM_PORTS*32-1:0]    src_tuser_in,
  input  logic                       tresp_tready_in,
  output logic                       tresp_tvalid_o,
  output logic                       tresp_tlast_o,
  output logic [63:0]                tresp_tdata_o,
  output logic [7:0]                 tresp_tkeep_o,
  output logic [31:0]                tresp_tuser_o,
  output logic [NUM_PORTS-1:0]       grant_o,
  output logic                       busy_o,
  output logic [NUM_PORTS*CNT_W-1:0] pkt_cnt_o
);

  localparam int IW = idx_w(NUM_PORTS);

  arb_state_t           r_state;
  logic [NUM_PORTS-1:0] r_grant;
  logic [IW-1:0]        r_last;

  logic [NUM_PORTS-1:0] w_pick_oh;
  logic [IW-1:0]        w_pick_idx;
  logic                 w_pick_vld;

  logic        w_vld;
  logic        w_last;
  logic [63:0] w_data;
  logic [7:0]  w_keep;
  logic [31:0] w_user;
  logic        w_done;

  rr_pick #(.N(NUM_PORTS), .IW(IW)) u_pick (
    .i_req      (src_tvalid_in),
    .i_last     (r_last),
    .o_pick_oh  (w_pick_oh),
    .o_pick_idx (w_pick_idx),
    .o_pick_vld (w_pick_vld)
  );

  // r_grant is zero outside PKT_s, so the mux yields all-zero when idle.
  always_comb begin
    w_vld  = 1'b0;
    w_last = 1'b0;
    w_data = '0;
    w_keep = '0;
    w_user = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant[i]) begin
        w_vld  = src_tvalid_in[i];
        w_last = src_tlast_in[i];
        w_data = src_tdata_in[64*i +: 64];
        w_keep = src_tkeep_in[8*i +: 8];
        w_user = src_tuser_in[32*i +: 32];
      end
    end
  end

  assign tresp_tvalid_o = w_vld;
  assign tresp_tlast_o  = w_vld & w_last;
  assign tresp_tdata_o  = w_vld ? w_data : '0;
  assign tresp_tkeep_o  = w_vld ? w_keep : '0;
  assign tresp_tuser_o  = w_vld ? w_user : '0;
  assign src_tready_o   = r_grant & {NUM_PORTS{tresp_tready_in}};
  assign w_done         = w_vld & tresp_tready_in & w_last;
  assign grant_o        = r_grant;
  assign busy_o         = (r_state == PKT_s);

  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      r_state <= IDLE_s;
      r_grant <= '0;
      r_last  <= IW'(NUM_PORTS - 1);
    end else begin
      unique case (r_state)
        IDLE_s: begin
          if (w_pick_vld) begin
            r_grant <= w_pick_oh;
            r_last  <= w_pick_idx;
            r_state <= PKT_s;
          end
        end
        PKT_s: begin
          if (w_done) begin
            r_grant <= '0;
            r_state <= IDLE_s;
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= IDLE_s;
        end
      endcase
    end
  end

`ifdef RESP_ARB_STATS_EN
  logic [NUM_PORTS-1:0][CNT_W-1:0] r_cnt;

  // Saturating so a long-running link never wraps back to a misleading small count.
  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_done && r_grant[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign pkt_cnt_o = r_cnt;
`else
  assign pkt_cnt_o = '0;
`endif

endmodule
